// File: rtl/regheap_accum_array.sv
// regheap_accum_array: LANES signed accumulators fed by one vector bus,
// framed by in_last, with ready/valid on both sides and sat/wrap arithmetic.
module regheap_accum_array #(
  parameter int LANES  = 64,
  parameter int DW     = 16,
  parameter int CNT_W  = 8,
  parameter int SAT_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                usr_clr,
  input  logic                in_v,
  output logic                in_rdy,
  input  logic                in_last,
  input  logic [LANES*DW-1:0] in_data,
  output logic                out_v,
  input  logic                out_rdy,
  output logic [LANES*DW-1:0] out_data,
  output logic [LANES-1:0]    out_ovf,
  output logic [CNT_W-1:0]    out_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DW-1:0] POS_FS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_FS = {1'b1, {(DW-1){1'b0}}};

  state_t state_q, state_d;

  logic [LANES*DW-1:0] acc_q, acc_d, sum;
  logic [LANES-1:0]    ovf_q, ovf_d, lane_ovf;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                idle, take, give;

  assign idle   = (state_q == IDLE);
  assign in_rdy = (state_q != HOLD);
  assign out_v  = (state_q == HOLD);

  // A beat arriving together with usr_clr is dropped.
  assign take = in_v & in_rdy & ~usr_clr;
  assign give = out_v & out_rdy & ~usr_clr;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   s;
    logic          o;

    // First beat of a frame adds onto zero through the same path.
    assign a = idle ? '0 : acc_q[g*DW +: DW];
    assign b = in_data[g*DW +: DW];
    assign s = {a[DW-1], a} + {b[DW-1], b};
    assign o = s[DW] ^ s[DW-1];

    assign lane_ovf[g] = o;
    assign sum[g*DW +: DW] =
      (o && (SAT_EN != 0)) ? (s[DW] ? NEG_FS : POS_FS)
                           : s[DW-1:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      usr_clr: begin
        state_d = IDLE;
        acc_d   = '0;
        ovf_d   = '0;
        cnt_d   = '0;
      end
      take: begin
        acc_d   = sum;
        ovf_d   = (idle ? '0 : ovf_q) | lane_ovf;
        if (idle)
          cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX)
          cnt_d = cnt_q + CNT_W'(1);
        state_d = in_last ? HOLD : ACC;
      end
      give: begin
        state_d = IDLE;
        acc_d   = '0;
        ovf_d   = '0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data = acc_q;
  assign out_ovf  = ovf_q;
  assign out_cnt  = cnt_q;

endmodule

// File: tb/tb_regheap_accum_array.sv
// tb_regheap_accum_array: scoreboard bench, saturating and wrapping
// instances share stimulus; an integer lane model predicts each frame.
`timescale 1ns/1ps
module tb_regheap_accum_array;

  localparam int LANES = 64;
  localparam int DW    = 16;
  localparam int CNT_W = 8;
  localparam int W     = LANES * DW;
  localparam int HALF  = 1 << (DW - 1);
  localparam int FULL  = 1 << DW;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic         clk = 0;
  logic         rst = 1;
  logic         usr_clr = 0;
  logic         in_v = 0;
  logic         in_last = 0;
  logic         out_rdy = 1;
  logic [W-1:0] in_data = '0;

  logic             in_rdy_s, in_rdy_w;
  logic             out_v_s, out_v_w;
  logic [W-1:0]     out_data_s, out_data_w;
  logic [LANES-1:0] out_ovf_s, out_ovf_w;
  logic [CNT_W-1:0] out_cnt_s, out_cnt_w;

  always #5 clk = ~clk;

  regheap_accum_array #(
    .LANES(LANES), .DW(DW), .CNT_W(CNT_W), .SAT_EN(1)
  ) dut_s (
    .clk(clk), .rst(rst), .usr_clr(usr_clr),
    .in_v(in_v), .in_rdy(in_rdy_s), .in_last(in_last),
    .in_data(in_data), .out_v(out_v_s), .out_rdy(out_rdy),
    .out_data(out_data_s), .out_ovf(out_ovf_s),
    .out_cnt(out_cnt_s)
  );

  regheap_accum_array #(
    .LANES(LANES), .DW(DW), .CNT_W(CNT_W), .SAT_EN(0)
  ) dut_w (
    .clk(clk), .rst(rst), .usr_clr(usr_clr),
    .in_v(in_v), .in_rdy(in_rdy_w), .in_last(in_last),
    .in_data(in_data), .out_v(out_v_w), .out_rdy(out_rdy),
    .out_data(out_data_w), .out_ovf(out_ovf_w),
    .out_cnt(out_cnt_w)
  );

  typedef struct {
    logic [W-1:0]     ds;
    logic [W-1:0]     dw;
    logic [LANES-1:0] os;
    logic [LANES-1:0] ow;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  int m_s[LANES];
  int m_w[LANES];
  bit [LANES-1:0] mo_s, mo_w;
  int m_cnt = 0;
  bit m_hold = 0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic chk_data(string n, logic [W-1:0] a, logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      for (int i = 0; i < LANES; i++)
        if (a[i*DW +: DW] !== e[i*DW +: DW]) begin
          $display("FAIL %s: lane %0d got %h want %h",
                   n, i, a[i*DW +: DW], e[i*DW +: DW]);
          break;
        end
    end
  endtask

  function automatic int lane_in(logic [W-1:0] d, int i);
    logic [DW-1:0] v;
    v = d[i*DW +: DW];
    return int'($signed(v));
  endfunction

  // Exact integer sum, then clamp or fold back into DW bits.
  function automatic int step(int a, int x, bit sat, output bit o);
    int s;
    s = a + x;
    o = (s > HALF - 1) || (s < -HALF);
    if (!o) return s;
    if (sat) return (s > 0) ? HALF - 1 : -HALF;
    return ((s + HALF + FULL) % FULL) - HALF;
  endfunction

  function automatic logic [W-1:0] fill(logic [DW-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic model_clear(bit drop);
    for (int i = 0; i < LANES; i++) begin
      m_s[i] = 0;
      m_w[i] = 0;
    end
    mo_s = '0;
    mo_w = '0;
    m_cnt = 0;
    if (drop && m_hold && sb.size() > 0) void'(sb.pop_back());
    m_hold = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    bit o;
    exp_t e;
    if (!rst) model_clear(1);
    else if (usr_clr) model_clear(1);
    else if (m_hold) begin
      if (out_rdy) model_clear(0);
    end else if (in_v) begin
      for (int i = 0; i < LANES; i++) begin
        m_s[i] = step(m_s[i], lane_in(in_data, i), 1, o);
        mo_s[i] = mo_s[i] | o;
        m_w[i] = step(m_w[i], lane_in(in_data, i), 0, o);
        mo_w[i] = mo_w[i] | o;
      end
      if (m_cnt < CMAX) m_cnt++;
      if (in_last) begin
        for (int i = 0; i < LANES; i++) begin
          e.ds[i*DW +: DW] = DW'(m_s[i]);
          e.dw[i*DW +: DW] = DW'(m_w[i]);
        end
        e.os = mo_s;
        e.ow = mo_w;
        e.cnt = CNT_W'(m_cnt);
        sb.push_back(e);
        m_hold = 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("in_rdy", 64'(in_rdy_s), 64'(!m_hold));
    chk("in_rdy_w", 64'(in_rdy_w), 64'(!m_hold));
    chk("out_v", 64'(out_v_s), 64'(m_hold));
    chk("out_v_w", 64'(out_v_w), 64'(m_hold));
    chk("cnt", 64'(out_cnt_s), 64'(m_cnt));
    chk("cnt_w", 64'(out_cnt_w), 64'(m_cnt));
    if (rst && out_v_s && out_rdy && !usr_clr) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got out_v=1 want no frame");
      end else begin
        e = sb.pop_front();
        chk_data("frame_sat", out_data_s, e.ds);
        chk_data("frame_wrap", out_data_w, e.dw);
        chk("frame_ovf_s", 64'(out_ovf_s), 64'(e.os));
        chk("frame_ovf_w", 64'(out_ovf_w), 64'(e.ow));
        chk("frame_cnt", 64'(out_cnt_s), 64'(e.cnt));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(logic [W-1:0] d, bit last);
    in_v = 1;
    in_data = d;
    in_last = last;
    tick(1);
    in_v = 0;
    in_last = 0;
  endtask

  function automatic logic [DW-1:0] rnd_lane();
    case ($urandom_range(0, 3))
      0: return DW'($urandom_range(0, 63));
      1: return 16'h7FFF;
      2: return 16'h8000;
      default: return DW'($urandom);
    endcase
  endfunction

  logic [W-1:0] d, e, snap;

  initial begin
    #1 rst = 0;
    tick(2);
    rst = 1;
    chk_data("rst_data", out_data_s, '0);
    chk("rst_ovf", 64'(out_ovf_s), 64'd0);
    chk("rst_cnt", 64'(out_cnt_s), 64'd0);
    chk("rst_out_v", 64'(out_v_s), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy_s), 64'd1);

    out_rdy = 1;
    for (int k = 0; k < 4; k++) beat(fill(16'h0010), k == 3);
    chk("t1_out_v", 64'(out_v_s), 64'd1);
    chk_data("t1_data", out_data_s, fill(16'h0040));
    chk("t1_cnt", 64'(out_cnt_s), 64'd4);
    chk("t1_ovf", 64'(out_ovf_s), 64'd0);
    tick(1);
    chk("t1_done", 64'(out_v_s), 64'd0);

    d = '0;
    d[15:0] = 16'h7000;
    beat(d, 0);
    d[15:0] = 16'h2000;
    beat(d, 1);
    e = '0;
    e[15:0] = 16'h7FFF;
    chk_data("t2_pos_sat", out_data_s, e);
    e[15:0] = 16'h9000;
    chk_data("t3_pos_wrap", out_data_w, e);
    chk("t2_ovf_s", 64'(out_ovf_s), 64'd1);
    chk("t3_ovf_w", 64'(out_ovf_w), 64'd1);
    tick(1);

    d[15:0] = 16'h8001;
    beat(d, 0);
    d[15:0] = 16'hFFF0;
    beat(d, 1);
    e[15:0] = 16'h8000;
    chk_data("t2_neg_sat", out_data_s, e);
    e[15:0] = 16'h7FF1;
    chk_data("t3_neg_wrap", out_data_w, e);
    chk("t2_neg_ovf", 64'(out_ovf_s), 64'd1);
    tick(1);

    out_rdy = 0;
    beat(fill(16'h0003), 0);
    beat(fill(16'h0005), 1);
    snap = out_data_s;
    chk_data("t4_sum", snap, fill(16'h0008));
    repeat (10) begin
      in_v = 1;
      in_last = 1;
      in_data = fill(DW'($urandom));
      tick(1);
      chk("t4_in_rdy", 64'(in_rdy_s), 64'd0);
      chk_data("t4_stable", out_data_s, snap);
    end
    in_v = 0;
    in_last = 0;
    out_rdy = 1;
    tick(1);
    chk("t4_release", 64'(out_v_s), 64'd0);
    beat(fill(16'h0001), 1);
    chk_data("t4_next", out_data_s, fill(16'h0001));
    tick(1);

    beat(fill(16'hFFFF), 1);
    chk_data("t5_data", out_data_s, fill(16'hFFFF));
    chk("t5_cnt", 64'(out_cnt_s), 64'd1);
    chk("t5_ovf", 64'(out_ovf_s), 64'd0);
    tick(1);

    for (int k = 0; k < 3; k++) beat(fill(16'h0100), 0);
    chk("t6_cnt3", 64'(out_cnt_s), 64'd3);
    usr_clr = 1;
    in_v = 1;
    in_data = fill(16'h7777);
    tick(1);
    usr_clr = 0;
    in_v = 0;
    chk_data("t6_clr_data", out_data_s, '0);
    chk("t6_clr_cnt", 64'(out_cnt_s), 64'd0);
    chk("t6_clr_ovf", 64'(out_ovf_s), 64'd0);
    beat(fill(16'h0002), 0);
    beat(fill(16'h0003), 1);
    chk_data("t6_after_clr", out_data_s, fill(16'h0005));
    tick(1);

    beat(fill(16'h0100), 0);
    beat(fill(16'h0100), 0);
    rst = 0;
    #2;
    chk_data("t6_rst_data", out_data_s, '0);
    chk("t6_rst_cnt", 64'(out_cnt_s), 64'd0);
    tick(1);
    rst = 1;
    beat(fill(16'h0007), 1);
    chk_data("t6_after_rst", out_data_s, fill(16'h0007));
    chk("t6_rst_cnt1", 64'(out_cnt_s), 64'd1);
    tick(1);

    in_v = 1;
    in_data = fill(16'h0001);
    tick(259);
    in_last = 1;
    tick(1);
    in_v = 0;
    in_last = 0;
    chk("cnt_sat", 64'(out_cnt_s), 64'(CMAX));
    chk_data("cnt_sat_data", out_data_s, fill(16'h0104));
    tick(1);

    repeat (600) begin
      in_v = ($urandom_range(0, 3) != 0);
      in_last = ($urandom_range(0, 3) == 0);
      out_rdy = ($urandom_range(0, 2) != 0);
      usr_clr = ($urandom_range(0, 40) == 0);
      for (int i = 0; i < LANES; i++) in_data[i*DW +: DW] = rnd_lane();
      tick(1);
    end
    in_v = 0;
    in_last = 0;
    usr_clr = 0;
    out_rdy = 1;
    tick(3);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
